inv_key_schedule: RTL and testbench

- Iterative inverse AES-128 key schedule for the decryption datapath.
- Accepts the round-10 key and streams round keys 10, 9, … 0 in the order the inverse cipher consumes them.
- Computes one round step per accepted transfer, so the full 1408-bit schedule is never stored.
- Sits between the key-load logic and the decrypt round engine; reuses the existing RotWord and SubWord modules.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/inv_key_round.sv | 26 ++
 rtl/rot_word.sv | 7 +
 rtl/sub_word.sv | 26 ++
 rtl/inv_key_schedule.sv | 102 ++++++++++
 tb/tb_inv_key_schedule.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and GF(2^8) helpers for the inverse key schedule.
package aes_pkg;

   localparam int unsigned NR     = 10;
   localparam int unsigned NK     = 4;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned KEY_W  = WORD_W * NK;
   localparam int unsigned IDX_W  = 4;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [KEY_W-1:0]  key_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   // Rcon for round r; rounds outside 1..10 contribute nothing
   function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
      logic [7:0] v;
      v = 8'h00;
      if (r >= IDX_W'(1) && r <= IDX_W'(NR)) v = RCON[r];
      return v;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // InvMixColumns on one column, top byte is row 0
   function automatic word_t inv_mix_col(input word_t c);
      logic [7:0] s, x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         s     = c[31-8*i -: 8];
         x2    = xtime(s);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ s;
         mb[i] = x8 ^ x2 ^ s;
         md[i] = x8 ^ x4 ^ s;
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

endpackage

// File: rtl/inv_key_round.sv
// One combinational inverse key-expansion step: round r key in, round r-1 key out.
module inv_key_round
   import aes_pkg::*;
(
   input  logic [KEY_W-1:0] a,
   input  logic [IDX_W-1:0] r,
   output logic [KEY_W-1:0] b
);
   word_t a0, a1, a2, a3;
   word_t b0, b1, b2, b3;
   word_t rot_w, sub_w;

   assign {a0, a1, a2, a3} = a;
   assign b3 = a3 ^ a2;
   assign b2 = a2 ^ a1;
   assign b1 = a1 ^ a0;

   rot_word u_rot (.a(b3), .y(rot_w));

   for (genvar i = 0; i < 4; i++) begin : g_sub
      sub_word u_sub (.a(rot_w[8*i +: 8]), .y(sub_w[8*i +: 8]));
   end

   assign b0 = a0 ^ sub_w ^ {rcon(r), 24'h000000};
   assign b  = {b0, b1, b2, b3};
endmodule

// File: rtl/rot_word.sv
// RotWord: cyclic left rotation of a word by one byte.
module rot_word (
   input  logic [31:0] a,
   output logic [31:0] y
);
   assign y = {a[23:0], a[31:24]};
endmodule

// File: rtl/sub_word.sv
// SubWord byte lane: AES forward S-box lookup.
module sub_word (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX[{a, 3'b000} +: 8];
endmodule

// File: rtl/inv_key_schedule.sv
// Iterative inverse AES-128 key schedule streaming round keys NR..0 over valid/ready.
// Build option INVKS_EQINV_EN: rounds 1..NR-1 are presented in equivalent-inverse-cipher form.
module inv_key_schedule
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [0:KEY_W-1] last_key,
   input  logic             rk_ready,
   output logic [0:KEY_W-1] round_key,
   output logic [IDX_W-1:0] round_idx,
   output logic             rk_valid,
   output logic             busy,
   output logic             done
);
   state_t           state, state_nxt;
   key_t             key_q, key_nxt, key_step;
   logic [IDX_W-1:0] idx_nxt;
   logic             valid_nxt, busy_nxt, done_nxt;
   logic             xfer;

   assign xfer = rk_valid & rk_ready;

   inv_key_round u_round (.a(key_q), .r(round_idx), .b(key_step));

   // State and registered outputs; the key register always holds the plain key
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         key_q     <= '0;
         round_idx <= '0;
         rk_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         key_q     <= key_nxt;
         round_idx <= idx_nxt;
         rk_valid  <= valid_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = EMIT;
         EMIT:    if (xfer && round_idx == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the datapath and output registers
   always_comb begin
      key_nxt   = key_q;
      idx_nxt   = round_idx;
      valid_nxt = rk_valid;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               key_nxt   = last_key;
               idx_nxt   = IDX_W'(NR);
               valid_nxt = 1'b1;
               busy_nxt  = 1'b1;
            end
         end
         EMIT: begin
            if (xfer) begin
               if (round_idx == '0) begin
                  valid_nxt = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  key_nxt = key_step;
                  idx_nxt = round_idx - IDX_W'(1);
               end
            end
         end
         default: begin
         end
      endcase
   end

`ifdef INVKS_EQINV_EN
   key_t key_eq;

   always_comb begin
      for (int i = 0; i < NK; i++)
         key_eq[WORD_W*i +: WORD_W] = inv_mix_col(key_q[WORD_W*i +: WORD_W]);
   end

   assign round_key = (round_idx != '0 && round_idx != IDX_W'(NR)) ? key_eq : key_q;
`else
   assign round_key = key_q;
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule against a forward KeyExpansion reference model.
module tb_inv_key_schedule;

   logic         clk;
   logic         reset;
   logic         start;
   logic [0:127] last_key;
   logic         rk_ready;
   logic [0:127] round_key;
   logic [3:0]   round_idx;
   logic         rk_valid;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;

`ifdef INVKS_EQINV_EN
   localparam bit EQ_MODE = 1'b1;
`else
   localparam bit EQ_MODE = 1'b0;
`endif

   logic [7:0]  sb [256];
   logic [31:0] w  [44];
   logic [7:0]  imc_base [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

   inv_key_schedule dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .last_key  (last_key),
      .rk_ready  (rk_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .rk_valid  (rk_valid),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   function automatic logic [31:0] imc_col(input logic [31:0] c);
      logic [31:0] o;
      logic [7:0]  acc;
      for (int i = 0; i < 4; i++) begin
         acc = 8'h00;
         for (int j = 0; j < 4; j++)
            acc ^= gmul(imc_base[(j - i + 4) % 4], c[31-8*j -: 8]);
         o[31-8*i -: 8] = acc;
      end
      return o;
   endfunction

   function automatic logic [127:0] imc_key(input logic [127:0] k);
      return {imc_col(k[127:96]), imc_col(k[95:64]), imc_col(k[63:32]), imc_col(k[31:0])};
   endfunction

   // Expected presented key for round r from the expanded schedule
   function automatic logic [127:0] exp_key(input int r);
      logic [127:0] k;
      k = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (EQ_MODE && r >= 1 && r <= 9) k = imc_key(k);
      return k;
   endfunction

   task automatic expand(input logic [127:0] k);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t ^= {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one full sequence from the key whose forward schedule is in w[]
   task automatic run_seq(input string name, input logic [127:0] k,
                          input bit rand_ready, input bit spam);
      int r;
      int cyc;
      expand(k);
      last_key = {w[40], w[41], w[42], w[43]};
      start    = 1'b1;
      rk_ready = 1'b1;
      tick();
      start = spam;
      r   = 10;
      cyc = 0;
      while (r >= 0 && cyc < 300) begin
         check($sformatf("%s valid r%0d", name, r), 128'(rk_valid), 128'(1));
         check($sformatf("%s busy r%0d", name, r), 128'(busy), 128'(1));
         check($sformatf("%s idx r%0d", name, r), 128'(round_idx), 128'(r));
         check($sformatf("%s key r%0d", name, r), round_key, exp_key(r));
         if (spam) last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
         rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         cyc++;
         if (rk_ready) r--;
      end
      check($sformatf("%s completed", name), 128'(r < 0), 128'(1));
      if (!rand_ready) check($sformatf("%s cycles", name), 128'(cyc), 128'(11));
      check($sformatf("%s done", name), 128'(done), 128'(1));
      check($sformatf("%s valid at done", name), 128'(rk_valid), 128'(0));
      check($sformatf("%s busy at done", name), 128'(busy), 128'(0));
      check($sformatf("%s key held", name), round_key, exp_key(0));
      start = 1'b0;
      tick();
      check($sformatf("%s done pulse", name), 128'(done), 128'(0));
      check($sformatf("%s idle valid", name), 128'(rk_valid), 128'(0));
   endtask

   initial begin
      logic [7:0]   inv;
      logic [127:0] fips;
      reset    = 1'b0;
      start    = 1'b0;
      rk_ready = 1'b0;
      last_key = '0;

      // Forward S-box built from GF(2^8) inversion and the affine map
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end

      repeat (2) tick();
      check("reset key", round_key, 128'h0);
      check("reset idx", 128'(round_idx), 128'(0));
      check("reset valid", 128'(rk_valid), 128'(0));
      check("reset busy", 128'(busy), 128'(0));
      check("reset done", 128'(done), 128'(0));
      reset = 1'b1;
      tick();

      // FIPS-197 A.1 with known-answer spot checks
      fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      expand(fips);
      check("fips w40..43", {w[40], w[41], w[42], w[43]}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      last_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      start    = 1'b1;
      rk_ready = 1'b1;
      tick();
      start = 1'b0;
      check("fips r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      tick();
      check("fips r9", round_key, EQ_MODE ? imc_key(128'hac7766f319fadc2128d12941575c006e)
                                          : 128'hac7766f319fadc2128d12941575c006e);
      repeat (8) tick();
      check("fips idx1", 128'(round_idx), 128'(1));
      check("fips r1", round_key, EQ_MODE ? imc_key(128'ha0fafe1788542cb123a339392a6c7605)
                                          : 128'ha0fafe1788542cb123a339392a6c7605);
      tick();
      check("fips r0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      tick();
      check("fips done", 128'(done), 128'(1));
      tick();

      run_seq("fips", fips, 1'b0, 1'b0);
      run_seq("bp", fips, 1'b1, 1'b0);
      run_seq("spam", fips, 1'b0, 1'b1);

      // Reset mid-sequence at round 5
      expand(fips);
      last_key = {w[40], w[41], w[42], w[43]};
      start    = 1'b1;
      rk_ready = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("mid idx", 128'(round_idx), 128'(5));
      reset = 1'b0;
      #1;
      check("abort valid", 128'(rk_valid), 128'(0));
      check("abort busy", 128'(busy), 128'(0));
      check("abort key", round_key, 128'h0);
      check("abort idx", 128'(round_idx), 128'(0));
      tick();
      check("abort done", 128'(done), 128'(0));
      reset = 1'b1;
      tick();
      check("post abort done", 128'(done), 128'(0));
      check("post abort valid", 128'(rk_valid), 128'(0));
      run_seq("fresh", fips, 1'b0, 1'b0);

      // Loopback with random keys
      for (int n = 0; n < 4; n++)
         run_seq($sformatf("rnd%0d", n), {$urandom(), $urandom(), $urandom(), $urandom()},
                 n[0], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
